// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and protocol constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE,
    PS2_DATA,
    PS2_PARITY,
    PS2_STOP
  } ps2_state_t;

  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // Prefix codes also decoded by the keyboard matrix stage
  localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
  localparam logic [7:0] PS2_CODE_REL = 8'hF0;

endpackage

// File: rtl/ps2_line_cond.sv
// PS/2 pin conditioning: 2-flop synchronisers, optional clock glitch filter
// (PS2_GLITCH_FILTER_EN) and registered falling-edge detect of the PS/2 clock.
module ps2_line_cond #(
`ifdef PS2_GLITCH_FILTER_EN
  parameter int unsigned FILTER_LEN = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_fall,
  output logic dat_s
);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_lvl;
  logic       dat_lvl;
  logic       clk_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  logic [FLT_W-1:0]      flt_cnt;
  logic                  flt_lvl;
  logic [FILTER_LEN-1:0] dat_dly;

  // Level follows the input only after FILTER_LEN consecutive differing cycles;
  // data rides a delay line of the same depth so the sample stays aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b1;
      dat_dly <= '1;
    end else begin
      dat_dly <= {dat_dly[FILTER_LEN-2:0], dat_sync[1]};
      if (clk_sync[1] == flt_lvl) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        flt_lvl <= clk_sync[1];
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign clk_lvl = flt_lvl;
  assign dat_lvl = dat_dly[FILTER_LEN-1];
`else
  assign clk_lvl = clk_sync[1];
  assign dat_lvl = dat_sync[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_d    <= 1'b1;
      clk_fall <= 1'b0;
      dat_s    <= 1'b1;
    end else begin
      clk_d    <= clk_lvl;
      clk_fall <= clk_d & ~clk_lvl;
      dat_s    <= dat_lvl;
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host frame receiver delivering one scan-code byte per frame.
// Optional clock glitch filter enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_US = 200
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_LEN = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_code_ready,
  output logic       scan_code_error,
  output logic       frame_active
);

  localparam int unsigned TMO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

  logic clk_fall;
  logic dat_s;

  ps2_line_cond
`ifdef PS2_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  u_line_cond (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .clk_fall (clk_fall),
    .dat_s    (dat_s)
  );

  ps2_state_t       state, state_n;
  logic [7:0]       shift_reg, shift_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             parity, parity_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [7:0]       code_n;
  logic             ready_n;
  logic             error_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= PS2_IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      parity          <= 1'b0;
      tmo_cnt         <= '0;
      scan_code       <= 8'h00;
      scan_code_ready <= 1'b0;
      scan_code_error <= 1'b0;
      frame_active    <= 1'b0;
    end else begin
      state           <= state_n;
      shift_reg       <= shift_n;
      bit_cnt         <= bit_cnt_n;
      parity          <= parity_n;
      tmo_cnt         <= tmo_n;
      scan_code       <= code_n;
      scan_code_ready <= ready_n;
      scan_code_error <= error_n;
      frame_active    <= (state_n != PS2_IDLE);
    end
  end

  // Frame sequencing; a fall in the same cycle as the timeout takes priority.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    bit_cnt_n = bit_cnt;
    parity_n  = parity;
    tmo_n     = tmo_cnt;
    code_n    = scan_code;
    ready_n   = 1'b0;
    error_n   = 1'b0;

    if (state != PS2_IDLE && tmo_cnt != TMO_W'(TMO_CYC)) begin
      tmo_n = tmo_cnt + TMO_W'(1);
    end

    if (clk_fall) begin
      tmo_n = '0;
      case (state)
        PS2_IDLE: begin
          if (dat_s == PS2_START_BIT) begin
            state_n   = PS2_DATA;
            bit_cnt_n = '0;
          end
        end
        PS2_DATA: begin
          shift_n = {dat_s, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = PS2_PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        PS2_PARITY: begin
          parity_n = dat_s;
          state_n  = PS2_STOP;
        end
        PS2_STOP: begin
          if (dat_s == PS2_STOP_BIT && (^{shift_reg, parity})) begin
            code_n  = shift_reg;
            ready_n = 1'b1;
          end else begin
            error_n = 1'b1;
          end
          state_n = PS2_IDLE;
        end
        default: state_n = PS2_IDLE;
      endcase
    end else if (state != PS2_IDLE && tmo_cnt == TMO_W'(TMO_CYC)) begin
      error_n = 1'b1;
      state_n = PS2_IDLE;
    end

    if (state_n == PS2_IDLE) begin
      tmo_n = '0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed + randomized bench for ps2_scan_rx with a PS/2 device model and
// a frame-level reference model of the expected scan code and pulse counts.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ   = 5_000_000;
  localparam int          CLK_HALF = 100;
  localparam int          CLK_PER  = 2 * CLK_HALF;
  localparam int          PS2_HALF = 40_000;
  localparam int          TMO_T    = 200_000;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       scan_code_error;
  logic       frame_active;

  ps2_scan_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (200)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ps2_clk         (ps2_clk),
    .ps2_dat         (ps2_dat),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .scan_code_error (scan_code_error),
    .frame_active    (frame_active)
  );

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   ready_cnt = 0;
  int   error_cnt = 0;
  int   both_cnt  = 0;
  int   wide_cnt  = 0;
  logic rdy_q = 1'b0;
  logic err_q = 1'b0;
  time  last_ready_t = 0;
  time  last_err_t   = 0;
  time  fall_t       = 0;
  logic [7:0] exp_code;

  // Pulse observer, sampled away from the active edge.
  always @(negedge clk) begin
    if (scan_code_ready) begin
      ready_cnt    <= ready_cnt + 1;
      last_ready_t <= $time;
    end
    if (scan_code_error) begin
      error_cnt  <= error_cnt + 1;
      last_err_t <= $time;
    end
    if (scan_code_ready && scan_code_error) both_cnt <= both_cnt + 1;
    if ((scan_code_ready && rdy_q) || (scan_code_error && err_q)) wide_cnt <= wide_cnt + 1;
    rdy_q <= scan_code_ready;
    err_q <= scan_code_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    #PS2_HALF;
    ps2_clk = 1'b0;
    fall_t  = $time;
    #PS2_HALF;
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic par_ok, input logic stop_ok);
    ps2_bit(PS2_START_BIT);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par_ok ? ~(^d) : (^d));
    ps2_bit(stop_ok ? PS2_STOP_BIT : ~PS2_STOP_BIT);
    ps2_dat = 1'b1;
  endtask

  // Reference: a frame is good iff odd parity holds and stop is 1.
  task automatic send_chk(input string tag, input logic [7:0] d, input logic par_ok, input logic stop_ok);
    int   r0, e0;
    logic good;
    time  lat;
    r0   = ready_cnt;
    e0   = error_cnt;
    good = par_ok && stop_ok;
    send(d, par_ok, stop_ok);
    @(negedge clk);
    if (good) exp_code = d;
    check({tag, ".ready"}, 32'(ready_cnt - r0), good ? 32'd1 : 32'd0);
    check({tag, ".error"}, 32'(error_cnt - e0), good ? 32'd0 : 32'd1);
    check({tag, ".code"}, 32'(scan_code), 32'(exp_code));
    check({tag, ".active"}, 32'(frame_active), 32'd0);
    lat = good ? last_ready_t - fall_t : last_err_t - fall_t;
    check({tag, ".latency"}, 32'(lat > 0 && lat <= 20 * CLK_PER), 32'd1);
  endtask

  initial begin
    int   r0, e0, waited;
    logic [7:0] d;
    int   k;

    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    exp_code = 8'h00;
    repeat (10) @(negedge clk);
    check("rst.code", 32'(scan_code), 32'h00);
    check("rst.ready", 32'(scan_code_ready), 32'd0);
    check("rst.error", 32'(scan_code_error), 32'd0);
    check("rst.active", 32'(frame_active), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    send_chk("t1", 8'h1C, 1'b1, 1'b1);
    send_chk("t2a", PS2_CODE_REL, 1'b1, 1'b1);
    send_chk("t2b", 8'h1C, 1'b1, 1'b1);
    send_chk("t3", 8'h5A, 1'b0, 1'b1);
    send_chk("t4a", 8'h29, 1'b1, 1'b0);
    send_chk("t4b", 8'h29, 1'b1, 1'b1);

    // Stalled frame: start + 4 data bits, then the line goes quiet.
    r0 = ready_cnt;
    e0 = error_cnt;
    ps2_bit(PS2_START_BIT);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    ps2_dat = 1'b1;
    @(negedge clk);
    check("t5.active_mid", 32'(frame_active), 32'd1);
    waited = 0;
    while (error_cnt == e0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("t5.error", 32'(error_cnt - e0), 32'd1);
    check("t5.window", 32'(last_err_t - fall_t >= TMO_T && last_err_t - fall_t <= TMO_T + 4000), 32'd1);
    @(negedge clk);
    check("t5.active", 32'(frame_active), 32'd0);
    check("t5.ready", 32'(ready_cnt - r0), 32'd0);
    send_chk("t5b", 8'h76, 1'b1, 1'b1);

    // Reset in the middle of a frame.
    r0 = ready_cnt;
    e0 = error_cnt;
    ps2_bit(PS2_START_BIT);
    for (int i = 0; i < 5; i++) ps2_bit(1'(i % 3 == 0));
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6.rst_code", 32'(scan_code), 32'h00);
    check("t6.rst_active", 32'(frame_active), 32'd0);
    reset    = 1'b1;
    exp_code = 8'h00;
    repeat (20) @(negedge clk);
    check("t6.no_pulse", 32'((ready_cnt - r0) + (error_cnt - e0)), 32'd0);
    check("t6.active", 32'(frame_active), 32'd0);
    send_chk("t6b", 8'h12, 1'b1, 1'b1);

`ifdef PS2_GLITCH_FILTER_EN
    // A 3-cycle clock blip while data is low must not start a frame.
    ps2_dat = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch.active", 32'(frame_active), 32'd0);
    ps2_dat = 1'b1;
    repeat (30) @(negedge clk);
`endif

    send_chk("ext", PS2_CODE_EXT, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      k = int'($urandom_range(0, 3));
      send_chk($sformatf("rnd%0d", n), d, k != 1, k != 2);
    end

    repeat (4) @(negedge clk);
    check("never_both", 32'(both_cnt), 32'd0);
    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
